// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types for the APB requester bridge.
//   - default APB address/data widths
//   - transfer FSM state encoding
//   - response bundle (rdata, err, timeout) at default widths for host-side code
package apb_master_pkg;

  localparam int APB_ADDR_W = 3;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_access_timer.sv
// apb_access_timer: counts ACCESS-phase wait cycles for the APB bridge.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - zero the count (asserted in the cycle before ACCESS)
//   enable      - count one wait cycle
//   expired     - count has reached TIMEOUT_CYCLES-1
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_access_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command channel -> single APB transfer
// (SETUP + ACCESS) -> valid/ready response channel. One transfer in flight.
// Ports:
//   PCLK, PRESETn                    - clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata - command channel (accepted only in IDLE)
//   rsp_valid/ready/rdata/err/timeout- response channel (held until rsp_ready)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA - registered APB request outputs
//   PREADY/PRDATA/PSLVERR            - APB completion inputs
//   xfer_count                       - completed transfers, wraps
// Optional: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without PREADY (reported as err + timeout).
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR,
  output logic [CNT_W-1:0]  xfer_count
);

  // Response bundle at this instance's data width.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

  apb_state_e state;
  rsp_t       rsp_q;
  logic       tmo;

  assign cmd_ready   = (state == ST_IDLE);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  logic expired;

  apb_access_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (state == ST_SETUP),
    .enable  ((state == ST_ACCESS) && !PREADY),
    .expired (expired)
  );

  // PREADY in the expiry cycle takes priority (normal completion path).
  assign tmo = expired && !PREADY;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
      xfer_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (cmd_valid) begin
          PADDR  <= cmd_addr;
          PWRITE <= cmd_write;
          PWDATA <= cmd_wdata;
          PSEL   <= 1'b1;          // visible in the SETUP cycle
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: if (PREADY) begin
          PSEL          <= 1'b0;
          PENABLE       <= 1'b0;
          rsp_q.rdata   <= PWRITE ? '0 : PRDATA;
          rsp_q.err     <= PSLVERR;
          rsp_q.timeout <= 1'b0;
          rsp_valid     <= 1'b1;
          xfer_count    <= xfer_count + 1'b1;
          state         <= ST_RESP;
        end else if (tmo) begin
          PSEL          <= 1'b0;
          PENABLE       <= 1'b0;
          rsp_q.rdata   <= '0;
          rsp_q.err     <= 1'b1;
          rsp_q.timeout <= 1'b1;
          rsp_valid     <= 1'b1;
          xfer_count    <= xfer_count + 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
